matrix_product_sequencer: RTL

//   Computes the eight element products of a 2x2 x 2x2 matrix multiply using one shared multiplier.

---
 rtl/matrix_product_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/matrix_product_sequencer.sv
// matrix_product_sequencer
//   Computes the eight element products of a 2x2 by 2x2 matrix multiply with a
//   single shared multiplier, one product per cycle. The results are packed in
//   slot order so that the downstream adder, summing adjacent pairs, produces
//   c00, c01, c10 and c11.
//
//   Slot map:
//     p0=a00*b00  p1=a01*b10  p2=a00*b01  p3=a01*b11
//     p4=a10*b00  p5=a11*b10  p6=a10*b01  p7=a11*b11
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   input handshake for matrix_a / matrix_b
//     matrix_a, matrix_b    packed elements, [E-1:0]=x00, then x01, x10, x11
//     out_valid / out_ready output handshake for products / overflow
//     products              eight ELEM_W slots, slot k at [(k+1)E-1:kE]
//     overflow              some product of this result exceeded ELEM_W bits
//     busy                  a pair is being multiplied or is waiting to drain
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for an input pair, in_ready high
//   S_MUL  | one product per cycle, slot selected by index_q
//   S_DONE | result complete and held, out_valid high until out_ready
module matrix_product_sequencer #(
    parameter int ELEM_W   = 6,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*ELEM_W-1:0]   matrix_a,
    input  logic [4*ELEM_W-1:0]   matrix_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*ELEM_W-1:0]   products,
    output logic                  overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             index_q, index_d;
    logic [4*ELEM_W-1:0]    a_q, a_d;
    logic [4*ELEM_W-1:0]    b_q, b_d;
    logic [8*ELEM_W-1:0]    products_q, products_d;
    logic                   overflow_q, overflow_d;

    logic [1:0]             a_sel;
    logic [1:0]             b_sel;
    logic [ELEM_W-1:0]      op_a;
    logic [ELEM_W-1:0]      op_b;
    logic [2*ELEM_W-1:0]    prod_full;
    logic                   prod_ovf;
    logic [ELEM_W-1:0]      prod_store;

    // index bit 2 picks the row of A, bit 0 the column of A (which is also
    // the row of B), bit 1 the column of B. This reproduces the slot map.
    always_comb begin
        a_sel      = {index_q[2], index_q[0]};
        b_sel      = {index_q[0], index_q[1]};
        op_a       = a_q[int'(a_sel)*ELEM_W +: ELEM_W];
        op_b       = b_q[int'(b_sel)*ELEM_W +: ELEM_W];
        prod_full  = (2*ELEM_W)'(op_a) * (2*ELEM_W)'(op_b);
        prod_ovf   = |prod_full[2*ELEM_W-1:ELEM_W];
        prod_store = (SATURATE && prod_ovf) ? {ELEM_W{1'b1}} : prod_full[ELEM_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        a_d        = a_q;
        b_d        = b_q;
        products_d = products_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = matrix_a;
                    b_d        = matrix_b;
                    products_d = '0;
                    overflow_d = 1'b0;
                    index_d    = 3'd0;
                    state_d    = S_MUL;
                end
            end
            S_MUL: begin
                products_d[int'(index_q)*ELEM_W +: ELEM_W] = prod_store;
                overflow_d = overflow_q | prod_ovf;
                index_d    = index_q + 3'd1;
                if (index_q == 3'd7) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            index_q    <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            products_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            a_q        <= a_d;
            b_q        <= b_d;
            products_q <= products_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign products  = products_q;
    assign overflow  = overflow_q;

endmodule
